// File: rtl/cas_pkg.sv
// rtl/cas_pkg.sv - shared types and helpers for the cassette FSK player
package cas_pkg;

  typedef enum logic [1:0] {
    KIND_DATA  = 2'd0,
    KIND_SHORT = 2'd1,
    KIND_LONG  = 2'd2,
    KIND_SIL   = 2'd3
  } kind_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TONE  = 3'd1,
    ST_SIL   = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    BV_ZERO = 2'd0,
    BV_ONE  = 2'd1,
    BV_SIL  = 2'd2
  } bitv_t;

  localparam int BITS_PER_BYTE = 11;

  // '0' is H H L L, '1' is H L H L, silence stays low
  function automatic logic quarter_level(input bitv_t v, input logic [1:0] idx);
    case (v)
      BV_ZERO: quarter_level = ~idx[1];
      BV_ONE:  quarter_level = ~idx[0];
      default: quarter_level = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cas_bit_gen.sv
// rtl/cas_bit_gen.sv - one FSK bit as four quarters of q ce ticks each
module cas_bit_gen
  import cas_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       run,
  input  logic       bit_start,
  input  bitv_t      bit_val,
  input  logic [9:0] q,
  output logic       level,
  output logic       bit_done
);

  logic [9:0] r_cnt, w_cnt_n;
  logic [1:0] r_idx, w_idx_n;
  bitv_t      r_val, w_val_n;
  logic       r_active, w_active_n;
  logic       r_level;
  logic       w_tick;

  assign w_tick   = run & ce & r_active;
  assign bit_done = w_tick & (r_idx == 2'd3) & (r_cnt == 10'd0);
  assign level    = r_level;

  always_comb begin
    w_cnt_n    = r_cnt;
    w_idx_n    = r_idx;
    w_val_n    = r_val;
    w_active_n = r_active;
    if (bit_start) begin
      w_cnt_n    = q - 10'd1;
      w_idx_n    = 2'd0;
      w_val_n    = bit_val;
      w_active_n = 1'b1;
    end else if (w_tick) begin
      if (r_cnt != 10'd0) begin
        w_cnt_n = r_cnt - 10'd1;
      end else if (r_idx == 2'd3) begin
        w_idx_n    = 2'd0;
        w_active_n = 1'b0;
      end else begin
        w_cnt_n = q - 10'd1;
        w_idx_n = r_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= 10'd0;
      r_idx    <= 2'd0;
      r_val    <= BV_ZERO;
      r_active <= 1'b0;
      r_level  <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_n;
      r_idx    <= w_idx_n;
      r_val    <= w_val_n;
      r_active <= w_active_n;
      // level is recomputed from the held position, so a frozen bit resumes where it stopped
      r_level  <= run & w_active_n & quarter_level(w_val_n, w_idx_n);
    end
  end

endmodule

// File: rtl/cas_fsk_player.sv
// rtl/cas_fsk_player.sv - token stream to MSX cassette FSK audio, gated by the motor line
module cas_fsk_player
  import cas_pkg::*;
#(
  parameter int Q1200     = 745,
  parameter int Q2400     = 373,
  parameter int HDR_LONG  = 8000,
  parameter int HDR_SHORT = 2000,
  parameter int SIL_BITS  = 1200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       motor,
  input  logic       baud_2400,
  input  logic [7:0] s_data,
  input  logic [1:0] s_kind,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       audio,
  output logic       busy
);

  localparam logic [9:0]  Q1200_W = 10'(Q1200);
  localparam logic [9:0]  Q2400_W = 10'(Q2400);
  localparam logic [14:0] HL_W    = 15'(HDR_LONG);
  localparam logic [14:0] HS_W    = 15'(HDR_SHORT);
  localparam logic [14:0] SIL_W   = 15'(SIL_BITS);
  localparam logic [14:0] BYTE_W  = 15'(BITS_PER_BYTE);

  state_t      r_state, w_state_n;
  logic [7:0]  r_shift, w_shift_n;
  logic [14:0] r_bit_cnt, w_bit_cnt_n;
  logic        r_baud, w_baud_n;
  logic        w_bit_start;
  bitv_t       w_bit_val;
  logic [9:0]  w_q;
  logic [14:0] w_hdr_bits;
  logic        w_bit_done;
  logic        w_level;

  assign s_ready = (r_state == ST_IDLE);
  assign busy    = (r_state != ST_IDLE);
  assign audio   = w_level;

  assign w_hdr_bits = (kind_t'(s_kind) == KIND_LONG) ? HL_W : HS_W;

  // r_bit_cnt holds the number of bits still to send after the current one
  always_comb begin
    w_state_n   = r_state;
    w_shift_n   = r_shift;
    w_bit_cnt_n = r_bit_cnt;
    w_baud_n    = r_baud;
    w_bit_start = 1'b0;
    w_bit_val   = BV_SIL;
    w_q         = r_baud ? Q2400_W : Q1200_W;
    if (r_state == ST_IDLE) begin
      if (s_valid) begin
        w_baud_n    = baud_2400;
        w_q         = baud_2400 ? Q2400_W : Q1200_W;
        w_shift_n   = s_data;
        w_bit_start = 1'b1;
        case (kind_t'(s_kind))
          KIND_DATA: begin
            w_state_n   = ST_START;
            w_bit_cnt_n = BYTE_W - 15'd1;
            w_bit_val   = BV_ZERO;
          end
          KIND_SHORT, KIND_LONG: begin
            w_state_n   = ST_TONE;
            w_bit_cnt_n = (baud_2400 ? (w_hdr_bits << 1) : w_hdr_bits) - 15'd1;
            w_bit_val   = BV_ONE;
          end
          default: begin
            w_state_n   = ST_SIL;
            w_bit_cnt_n = SIL_W - 15'd1;
            w_bit_val   = BV_SIL;
          end
        endcase
      end
    end else if (w_bit_done) begin
      if (r_bit_cnt == 15'd0) begin
        w_state_n = ST_IDLE;
      end else begin
        w_bit_cnt_n = r_bit_cnt - 15'd1;
        w_bit_start = 1'b1;
        case (r_state)
          ST_START: begin
            w_state_n = ST_DATA;
            w_bit_val = r_shift[0] ? BV_ONE : BV_ZERO;
          end
          ST_DATA: begin
            w_shift_n = r_shift >> 1;
            if (r_bit_cnt == 15'd2) begin
              w_state_n = ST_STOP;
              w_bit_val = BV_ONE;
            end else begin
              w_bit_val = r_shift[1] ? BV_ONE : BV_ZERO;
            end
          end
          ST_TONE, ST_STOP: w_bit_val = BV_ONE;
          default:          w_bit_val = BV_SIL;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= 8'd0;
      r_bit_cnt <= 15'd0;
      r_baud    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_shift   <= w_shift_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_baud    <= w_baud_n;
    end
  end

  cas_bit_gen u_bit_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .run       (motor),
    .bit_start (w_bit_start),
    .bit_val   (w_bit_val),
    .q         (w_q),
    .level     (w_level),
    .bit_done  (w_bit_done)
  );

endmodule

// File: tb/tb_cas_fsk_player.sv
// tb/tb_cas_fsk_player.sv - scoreboard bench for cas_fsk_player
module tb_cas_fsk_player;

  localparam int Q12 = 4;
  localparam int Q24 = 2;
  localparam int HS  = 3;
  localparam int HL  = 4;
  localparam int SB  = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b1;
  logic       motor = 1'b1;
  logic       baud_2400 = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic [1:0] s_kind = 2'd0;
  logic       s_valid = 1'b0;
  logic       s_ready, audio, busy;

  int checks = 0;
  int errors = 0;

  bit exp_q[$];
  int len_q[$];
  bit mon_en = 1'b0;
  bit tok_on = 1'b0;
  bit acc_prev = 1'b0;
  bit m_prev = 1'b1;
  int remaining = 0;

  cas_fsk_player #(
    .Q1200     (Q12),
    .Q2400     (Q24),
    .HDR_LONG  (HL),
    .HDR_SHORT (HS),
    .SIL_BITS  (SB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .motor     (motor),
    .baud_2400 (baud_2400),
    .s_data    (s_data),
    .s_kind    (s_kind),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .audio     (audio),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // v: 0 = '0', 1 = '1', 2 = silence
  task automatic push_bit(input int v, input int q);
    for (int qi = 0; qi < 4; qi++)
      for (int t = 0; t < q; t++)
        exp_q.push_back((v == 2) ? 1'b0 : ((v == 1) ? (qi % 2 == 0) : (qi < 2)));
  endtask

  task automatic expect_token(input int kind, input logic [7:0] d, input bit b);
    int q;
    int n;
    q = b ? Q24 : Q12;
    n = 0;
    if (kind == 0) begin
      push_bit(0, q);
      for (int i = 0; i < 8; i++) push_bit(d[i] ? 1 : 0, q);
      push_bit(1, q);
      push_bit(1, q);
      n = 11;
    end else if (kind == 1 || kind == 2) begin
      n = ((kind == 1) ? HS : HL) * (b ? 2 : 1);
      for (int i = 0; i < n; i++) push_bit(1, q);
    end else begin
      n = SB;
      for (int i = 0; i < n; i++) push_bit(2, q);
    end
    len_q.push_back(n * 4 * q);
  endtask

  task automatic send(input int kind, input logic [7:0] d, input bit b);
    int n;
    n = 0;
    expect_token(kind, d, b);
    s_kind    = 2'(kind);
    s_data    = d;
    baud_2400 = b;
    s_valid   = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", n < 2000, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((tok_on || acc_prev || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("token_done_in_time", n < 3000, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (tok_on || acc_prev) begin
          if (!tok_on) begin
            tok_on = 1'b1;
            if (len_q.size() == 0) begin
              check("spurious_accept", 1'b1, 1'b0);
              remaining = 0;
              tok_on = 1'b0;
            end else begin
              remaining = len_q.pop_front();
            end
          end
          if (tok_on) begin
            check("busy_in_token", busy, 1'b1);
            check("ready_in_token", s_ready, 1'b0);
            if (m_prev) begin
              e = exp_q.pop_front();
              check("audio", audio, e);
              remaining--;
              if (remaining == 0) tok_on = 1'b0;
            end else begin
              check("audio_motor_off", audio, 1'b0);
            end
          end
        end else begin
          check("idle_audio", audio, 1'b0);
          check("idle_busy", busy, 1'b0);
          check("idle_ready", s_ready, 1'b1);
        end
      end
      acc_prev = s_valid & s_ready;
      m_prev   = motor;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_audio", audio, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_ready", s_ready, 1'b1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;

    send(0, 8'h01, 1'b0);
    s_valid = 1'b0;
    wait_idle();

    send(1, 8'h00, 1'b1);
    s_valid = 1'b0;
    wait_idle();

    send(2, 8'h00, 1'b0);
    s_valid = 1'b0;
    wait_idle();

    send(0, 8'hA5, 1'b0);
    s_valid = 1'b0;
    repeat (36) @(posedge clk);
    #1;
    motor = 1'b0;
    baud_2400 = 1'b1;
    repeat (50) @(posedge clk);
    #1 motor = 1'b1;
    wait_idle();

    send(3, 8'h00, 1'b0);
    send(0, 8'hFF, 1'b0);
    s_valid = 1'b0;
    wait_idle();

    send(0, 8'h3C, 1'b0);
    s_valid = 1'b0;
    repeat (40) @(posedge clk);
    mon_en = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_audio", audio, 1'b0);
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_ready", s_ready, 1'b1);
    exp_q.delete();
    len_q.delete();
    tok_on = 1'b0;
    remaining = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    send(0, 8'h5A, 1'b0);
    s_valid = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
